// File: rtl/lwe_decryptor_if.sv
// Handshake bundle between ciphertext buffer, LWE decryptor and plaintext bit sink.
// noise_mag only exists when LWE_DEC_NOISE_MON_EN is defined.
interface lwe_decryptor_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned KEY_WIDTH  = 3
) ();
  logic                    ct_valid;
  logic                    ct_ready;
  logic [4*DATA_WIDTH-1:0] ct_u;
  logic [DATA_WIDTH-1:0]   ct_v;
  logic                    key_we;
  logic [1:0]              key_idx;
  logic [KEY_WIDTH-1:0]    key_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_bit;
  logic                    busy;
`ifdef LWE_DEC_NOISE_MON_EN
  logic [DATA_WIDTH-2:0]   noise_mag;

  modport master (
    output ct_valid, ct_u, ct_v, key_we, key_idx, key_data, m_ready,
    input  ct_ready, m_valid, m_bit, busy, noise_mag
  );
  modport slave (
    input  ct_valid, ct_u, ct_v, key_we, key_idx, key_data, m_ready,
    output ct_ready, m_valid, m_bit, busy, noise_mag
  );
`else
  modport master (
    output ct_valid, ct_u, ct_v, key_we, key_idx, key_data, m_ready,
    input  ct_ready, m_valid, m_bit, busy
  );
  modport slave (
    input  ct_valid, ct_u, ct_v, key_we, key_idx, key_data, m_ready,
    output ct_ready, m_valid, m_bit, busy
  );
`endif
endinterface

// File: rtl/lwe_decryptor.sv
// LWE decrypt: d = v - <u,s> mod 2^DATA_WIDTH with one MAC per cycle, decoded to one bit.
// Define LWE_DEC_NOISE_MON_EN to add the registered noise_mag monitor output.
module lwe_decryptor #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned KEY_WIDTH  = 3
) (
  input logic           clk,
  input logic           rst,
  lwe_decryptor_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned KW = KEY_WIDTH;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e          state_q, state_d;
  logic [4*DW-1:0] u_q, u_d;
  logic [4*KW-1:0] s_q, s_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [1:0]      idx_q, idx_d;
  logic            m_valid_q, m_valid_d;
  logic            m_bit_q, m_bit_d;

  logic [DW-1:0]   u_sel, s_ext, prod, acc_next;
  logic [KW-1:0]   s_sel;
  logic            dec_bit;

  // Low DW bits of the product are the same for signed and unsigned views, so a plain
  // DW x DW multiply of zero-extended u and sign-extended s is exact mod Q.
  assign u_sel    = u_q[idx_q*DW +: DW];
  assign s_sel    = s_q[idx_q*KW +: KW];
  assign s_ext    = {{(DW-KW){s_sel[KW-1]}}, s_sel};
  assign prod     = u_sel * s_ext;
  assign acc_next = acc_q - prod;
  assign dec_bit  = acc_next[DW-1] ^ acc_next[DW-2];

`ifdef LWE_DEC_NOISE_MON_EN
  logic [DW-2:0] noise_q, noise_d;
  logic [DW-1:0] err;
  assign err = acc_next - {dec_bit, {(DW-1){1'b0}}};
  assign bus.noise_mag = noise_q;
`endif

  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    s_d       = s_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_bit_d   = m_bit_q;
`ifdef LWE_DEC_NOISE_MON_EN
    noise_d   = noise_q;
`endif
    // Key is only writable while idle so an in-flight ciphertext sees a fixed key.
    if (state_q == StIdle && bus.key_we) begin
      s_d[bus.key_idx*KW +: KW] = bus.key_data;
    end
    unique case (state_q)
      StIdle: begin
        if (bus.ct_valid) begin
          u_d     = bus.ct_u;
          acc_d   = bus.ct_v;
          idx_d   = 2'd0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_next;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d   = StOut;
          m_valid_d = 1'b1;
          m_bit_d   = dec_bit;
`ifdef LWE_DEC_NOISE_MON_EN
          noise_d   = err[DW-1] ? (DW-1)'(-err) : err[DW-2:0];
`endif
        end
      end
      StOut: begin
        if (bus.m_ready) begin
          state_d   = StIdle;
          m_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      u_q       <= '0;
      s_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_bit_q   <= 1'b0;
`ifdef LWE_DEC_NOISE_MON_EN
      noise_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      u_q       <= u_d;
      s_q       <= s_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_bit_q   <= m_bit_d;
`ifdef LWE_DEC_NOISE_MON_EN
      noise_q   <= noise_d;
`endif
    end
  end

  assign bus.ct_ready = (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.m_valid  = m_valid_q;
  assign bus.m_bit    = m_bit_q;

endmodule

// File: tb/tb_lwe_decryptor.sv
// Directed bench for lwe_decryptor (DW=12, Q=4096) with hand-computed expected results.
// noise_mag is checked only when LWE_DEC_NOISE_MON_EN is defined.
module tb_lwe_decryptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lwe_decryptor_if #(.DATA_WIDTH(12), .KEY_WIDTH(3)) bus_if ();

  lwe_decryptor #(.DATA_WIDTH(12), .KEY_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_keys(input int k0, input int k1, input int k2, input int k3);
    int k[4];
    k = '{k0, k1, k2, k3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.key_we   = 1'b1;
      bus_if.key_idx  = 2'(i);
      bus_if.key_data = 3'(k[i]);
    end
    @(negedge clk);
    bus_if.key_we = 1'b0;
  endtask

  // Accepts one ciphertext, checks the 4-cycle latency and the decoded result, optionally
  // completes the output handshake. kwe drives a key write in the accept cycle.
  task automatic run_ct(input string tag, input logic [11:0] u0, input logic [11:0] u1,
                        input logic [11:0] u2, input logic [11:0] u3, input logic [11:0] v,
                        input logic eb, input logic [10:0] en, input bit hs,
                        input bit kwe, input int kidx, input int kdat);
    @(negedge clk);
    check({tag, ".ct_ready"}, 32'(bus_if.ct_ready), 32'd1);
    bus_if.ct_valid = 1'b1;
    bus_if.ct_u     = {u3, u2, u1, u0};
    bus_if.ct_v     = v;
    bus_if.key_we   = kwe;
    bus_if.key_idx  = 2'(kidx);
    bus_if.key_data = 3'(kdat);
    @(posedge clk);
    @(negedge clk);
    bus_if.ct_valid = 1'b0;
    bus_if.key_we   = 1'b0;
    check({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, ".m_valid_lat"}, 32'(bus_if.m_valid), 32'(k == 4));
    end
    check({tag, ".m_bit"}, 32'(bus_if.m_bit), 32'(eb));
`ifdef LWE_DEC_NOISE_MON_EN
    check({tag, ".noise_mag"}, 32'(bus_if.noise_mag), 32'(en));
`else
    if (en > 11'd1024) $display("note: %s expected noise out of range", tag);
`endif
    if (hs) begin
      bus_if.m_ready = 1'b1;
      @(negedge clk);
      bus_if.m_ready = 1'b0;
      check({tag, ".m_valid_drop"}, 32'(bus_if.m_valid), 32'd0);
      check({tag, ".ct_ready_back"}, 32'(bus_if.ct_ready), 32'd1);
    end
  endtask

  initial begin
    bit saw_valid;
    bus_if.ct_valid = 1'b0;
    bus_if.ct_u     = '0;
    bus_if.ct_v     = '0;
    bus_if.key_we   = 1'b0;
    bus_if.key_idx  = '0;
    bus_if.key_data = '0;
    bus_if.m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset.ct_ready", 32'(bus_if.ct_ready), 32'd1);
    check("reset.m_valid", 32'(bus_if.m_valid), 32'd0);
    check("reset.m_bit", 32'(bus_if.m_bit), 32'd0);
    check("reset.busy", 32'(bus_if.busy), 32'd0);
`ifdef LWE_DEC_NOISE_MON_EN
    check("reset.noise_mag", 32'(bus_if.noise_mag), 32'd0);
`endif

    // Decision thresholds with s=0 (key is zero out of reset): d = v.
    run_ct("thr1023", 12'd0, 12'd0, 12'd0, 12'd0, 12'd1023, 1'b0, 11'd1023, 1'b1, 1'b0, 0, 0);
    run_ct("thr1024", 12'd0, 12'd0, 12'd0, 12'd0, 12'd1024, 1'b1, 11'd1024, 1'b1, 1'b0, 0, 0);
    run_ct("thr3071", 12'd0, 12'd0, 12'd0, 12'd0, 12'd3071, 1'b1, 11'd1023, 1'b1, 1'b0, 0, 0);
    run_ct("thr3072", 12'd0, 12'd0, 12'd0, 12'd0, 12'd3072, 1'b0, 11'd1024, 1'b1, 1'b0, 0, 0);

    // d = 2148 - 100 = 2048
    set_keys(1, 0, 0, 0);
    run_ct("basic", 12'd100, 12'd0, 12'd0, 12'd0, 12'd2148, 1'b1, 11'd0, 1'b1, 1'b0, 0, 0);

    // <u,s> = 10 - 20 + 60 - 160 = -110, d = 115
    set_keys(1, -1, 2, -4);
    run_ct("mixed", 12'd10, 12'd20, 12'd30, 12'd40, 12'd5, 1'b0, 11'd115, 1'b1, 1'b0, 0, 0);

    // each term 4095*(-4) = 4 mod Q, d = -16 = 4080
    set_keys(-4, -4, -4, -4);
    run_ct("wrap", 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd0, 1'b0, 11'd16, 1'b1,
           1'b0, 0, 0);

    // Back-pressure: output held, pending ct and key write ignored.
    set_keys(1, 0, 0, 0);
    run_ct("hold", 12'd100, 12'd0, 12'd0, 12'd0, 12'd2148, 1'b1, 11'd0, 1'b0, 1'b0, 0, 0);
    bus_if.ct_valid = 1'b1;
    bus_if.ct_u     = {12'd0, 12'd0, 12'd1000, 12'd0};
    bus_if.ct_v     = 12'd0;
    bus_if.key_we   = 1'b1;
    bus_if.key_idx  = 2'd1;
    bus_if.key_data = 3'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold.m_valid", 32'(bus_if.m_valid), 32'd1);
      check("hold.m_bit", 32'(bus_if.m_bit), 32'd1);
      check("hold.ct_ready", 32'(bus_if.ct_ready), 32'd0);
    end
    bus_if.ct_valid = 1'b0;
    bus_if.key_we   = 1'b0;
    bus_if.m_ready  = 1'b1;
    @(negedge clk);
    bus_if.m_ready  = 1'b0;
    check("hold.release_valid", 32'(bus_if.m_valid), 32'd0);
    check("hold.release_ready", 32'(bus_if.ct_ready), 32'd1);
    // s1 still 0 -> d = 0; had the write landed, d = -3000 = 1096 -> bit 1.
    run_ct("hold_key", 12'd0, 12'd1000, 12'd0, 12'd0, 12'd0, 1'b0, 11'd0, 1'b1, 1'b0, 0, 0);

    // Key write in the accept cycle is used: s0 0 -> 1, d = -2048 = 2048.
    set_keys(0, 0, 0, 0);
    run_ct("samecyc", 12'd2048, 12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 11'd0, 1'b1, 1'b1, 0, 1);

    // Reset during MAC idx 2 (s0 = 1 from previous step).
    @(negedge clk);
    bus_if.ct_valid = 1'b1;
    bus_if.ct_u     = {12'd0, 12'd0, 12'd0, 12'd100};
    bus_if.ct_v     = 12'd0;
    @(posedge clk);
    @(negedge clk);
    bus_if.ct_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.m_valid", 32'(bus_if.m_valid), 32'd0);
    check("rst_mid.ct_ready", 32'(bus_if.ct_ready), 32'd1);
    check("rst_mid.busy", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.m_valid) saw_valid = 1'b1;
    end
    check("rst_mid.no_output", 32'(saw_valid), 32'd0);
    // s cleared -> d = 0; with s0 still 1, d = -2048 = 2048 -> bit 1.
    run_ct("rst_key", 12'd2048, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 11'd0, 1'b1, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
